rr_arb_mux: RTL
===============

// Module: rr_arb_mux
// PURPOSE
//  Parametrised N-channel round-robin arbitrated multiplexer with valid/ready handshake per channel.
//  Successor to the combinational 4:1 MUX and priority ENCODER library cells.
//  Selects one requesting input channel per cycle, registers its data and channel index, and presents them downstream.
//  Sits between multiple producers and one shared sink (bus, UART TX, display path).
// PARAMETERS
//  NCH   4  number of input channels, >=2
//  DW    8  data width per channel
//  SELW  derived localparam = $clog2(NCH); width of channel index
// PORTS
//  clk        in   1         system clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   NCH       per-channel request; bit i = channel i
//  in_data    in   NCH*DW    packed data; channel i at [i*DW +: DW]
//  in_ready   out  NCH       per-channel accept; at most one bit high
//  in_last    in   NCH       per-channel end-of-packet; used only with ARB_PKT_LOCK_EN
//  out_valid  out  1         output register holds valid word
//  out_data   out  DW        registered data of granted channel
//  out_sel    out  SELW      registered index of granted channel
//  out_last   out  1         registered in_last of granted channel (0 without ARB_PKT_LOCK_EN)
//  out_ready  in   1         downstream accept
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0, out_last=0, rr_ptr=0, lock=0; in_ready=0 while rst_n=0.
//  load = ~out_valid | out_ready (output slot free or being drained this cycle).
//  Grant: first channel with in_valid=1 searching i = rr_ptr, rr_ptr+1, ... NCH-1, 0, ... rr_ptr-1 (mod NCH).
//  in_ready[g] = load & in_valid[g] for granted g only; all other in_ready bits 0. Combinational from in_valid/out_ready.
//  Transfer on channel g when in_valid[g] & in_ready[g]: next edge out_data<=in_data[g], out_sel<=g, out_valid<=1.
//  Latency: input accept -> out_valid one cycle. Throughput: one word/cycle when out_ready held high.
//  After a transfer on g: rr_ptr <= (g==NCH-1) ? 0 : g+1 (wrap-around); granted channel becomes lowest priority.
//  No request and load: out_valid<=0 on next edge; rr_ptr unchanged.
//  out_valid & ~out_ready: output register, out_sel and rr_ptr hold; in_ready all 0 (stall, no data loss).
//  Simultaneous drain and fill (out_valid & out_ready & new request): register replaced in same edge, no bubble.
//  Single requester always granted regardless of rr_ptr; no starvation: any held request served within NCH transfers.
//  Inputs must hold in_valid/in_data stable until accepted; dropping in_valid before accept is a protocol error (undefined grant).
//  Reset mid-operation: in-flight word discarded, out_valid=0 asynchronously; arbitration restarts from channel 0.
//  NCH not power of 2: indices >= NCH never granted; rr_ptr wraps at NCH-1.
//  FSM (lock control, ARB_PKT_LOCK_EN only): ARB -> LOCKED on transfer with in_last[g]=0 (lock_ch<=g);
//   LOCKED: only lock_ch may be granted, others see in_ready=0; LOCKED -> ARB on transfer with in_last[lock_ch]=1.
//   rr_ptr advances only on the transfer returning to ARB.
// CONFIGURATION
//  ARB_PKT_LOCK_EN defined: packet-lock FSM active; in_last honoured; out_last <= in_last[g]; packets never interleave.
//  ARB_PKT_LOCK_EN undefined: pure per-word round-robin; in_last ignored; out_last tied 0; no lock state logic.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> out_valid=0, out_sel=0, in_ready=0 immediately; first grant after release to ch0 if requesting.
//  2 All 4 ch valid, out_ready=1, data=8'hA0+i -> out_sel sequence 0,1,2,3,0 ... out_data A0,A1,A2,A3,A0; one word/cycle.
//  3 Only ch2 valid, rr_ptr=3 -> ch2 granted, out_sel=2, rr_ptr->3 (wrap path 3->0->1->2 search).
//  4 out_valid=1, out_ready=0 for 5 cycles with ch1 valid -> out_data stable, in_ready=0; on out_ready=1 ch1 accepted same cycle.
//  5 NCH=3: ch2 and ch0 valid alternately -> rr_ptr wraps 2->0; no out_sel value 3 ever.
//  6 ARB_PKT_LOCK_EN: ch1 sends 3 words (in_last on 3rd) with ch0,ch3 valid -> out_sel 1,1,1 then 3, then 0; out_last=1 only on 3rd word.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbitrated multiplexer with per-channel
// valid/ready handshake and a registered output stage.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel request (bit i = channel i)
//   in_data    packed channel data, channel i at [i*DW +: DW]
//   in_ready   per-channel accept, at most one bit high
//   in_last    per-channel end-of-packet (honoured only with ARB_PKT_LOCK_EN)
//   out_valid  output register holds a valid word
//   out_data   registered data of the granted channel
//   out_sel    registered index of the granted channel
//   out_last   registered in_last of the granted channel (0 without lock)
//   out_ready  downstream accept
//
// Build option: define ARB_PKT_LOCK_EN to enable packet locking, so a
// channel keeps the grant from its first word until its in_last word.
//
// Lock FSM (ARB_PKT_LOCK_EN only)
//   state     | meaning
//   ST_ARB    | free round-robin arbitration between all requesters
//   ST_LOCKED | mid-packet; only lock_ch_q may be granted
module rr_arb_mux #(
    parameter  int NCH  = 4,
    parameter  int DW   = 8,
    localparam int SELW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH-1:0]    in_last,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [SELW-1:0]   out_sel,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int CW = SELW + 1;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q,  out_data_d;
    logic [SELW-1:0] out_sel_q,   out_sel_d;
    logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

    logic            load;
    logic            xfer;
    logic            grant_vld;
    logic [SELW-1:0] grant_idx;
    logic [SELW-1:0] ptr_next;
    logic [CW-1:0]   cand;
    logic [SELW-1:0] cand_idx;
    logic            eligible;

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q,   state_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;
    logic            out_last_q, out_last_d;
`endif

    assign load = ~out_valid_q | out_ready;

    // Search starts at rr_ptr and wraps at NCH-1, so indices >= NCH are
    // never visited even when NCH is not a power of two.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        cand_idx  = '0;
        eligible  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NCH)) begin
                cand = cand - CW'(NCH);
            end
            cand_idx = cand[SELW-1:0];
            eligible = in_valid[cand_idx];
`ifdef ARB_PKT_LOCK_EN
            if (state_q == ST_LOCKED && cand_idx != lock_ch_q) begin
                eligible = 1'b0;
            end
`endif
            if (!grant_vld && eligible) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Gated with rst_n so nothing is accepted while reset is asserted.
    assign xfer = rst_n & load & grant_vld;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign ptr_next = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef ARB_PKT_LOCK_EN
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        out_last_d  = out_last_q;
`endif
        if (load) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d = in_data[grant_idx*DW +: DW];
            out_sel_d  = grant_idx;
`ifdef ARB_PKT_LOCK_EN
            out_last_d = in_last[grant_idx];
            if (in_last[grant_idx]) begin
                // End of packet: release lock and rotate priority.
                state_d  = ST_ARB;
                rr_ptr_d = ptr_next;
            end else begin
                state_d   = ST_LOCKED;
                lock_ch_d = grant_idx;
            end
`else
            rr_ptr_d = ptr_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef ARB_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            lock_ch_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_ch_q  <= lock_ch_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`else
    logic unused_in_last;
    assign unused_in_last = ^in_last;
    assign out_last       = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
